// File: rtl/decoder_scan_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | decoder_scan_unit                                                          |
// | Registered SEL_W-to-2^SEL_W one-hot decoder with direct and scan modes.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module decoder_scan_unit #(
    parameter int SEL_W = 5,
    parameter int DWELL = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enabled,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        select_bits,
    input  logic                    start,
    input  logic [SEL_W-1:0]        scan_last,
    output logic [(2**SEL_W)-1:0]   returnVal,
    output logic [SEL_W-1:0]        index,
    output logic                    busy,
    output logic                    done
);

    localparam int OUT_W = 2**SEL_W;
    localparam logic [OUT_W-1:0] c_one        = {{(OUT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       c_dwell_last = 8'(DWELL - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t             r_state;
    logic [OUT_W-1:0]   r_return_val;
    logic [SEL_W-1:0]   r_index;
    logic [SEL_W-1:0]   r_last;
    logic [7:0]         r_dwell_cnt;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nxt;
    logic [OUT_W-1:0]   w_return_val_nxt;
    logic [SEL_W-1:0]   w_index_nxt;
    logic [SEL_W-1:0]   w_last_nxt;
    logic [7:0]         w_dwell_cnt_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_return_val <= '0;
            r_index      <= '0;
            r_last       <= '0;
            r_dwell_cnt  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_return_val <= w_return_val_nxt;
            r_index      <= w_index_nxt;
            r_last       <= w_last_nxt;
            r_dwell_cnt  <= w_dwell_cnt_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_return_val_nxt = r_return_val;
        w_index_nxt      = r_index;
        w_last_nxt       = r_last;
        w_dwell_cnt_nxt  = r_dwell_cnt;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_index_nxt     = '0;
                w_busy_nxt      = 1'b0;
                w_dwell_cnt_nxt = '0;
                if (!enabled) begin
                    w_return_val_nxt = '0;
                end else if (!mode) begin
                    w_return_val_nxt = c_one << select_bits;
                end else if (start) begin
                    w_last_nxt       = scan_last;
                    w_return_val_nxt = c_one;
                    w_busy_nxt       = 1'b1;
                    w_state_nxt      = ST_SCAN;
                end else begin
                    w_return_val_nxt = '0;
                end
            end

            ST_SCAN: begin
                if (!enabled) begin
                    // Abort: no done pulse, straight back to idle.
                    w_return_val_nxt = '0;
                    w_index_nxt      = '0;
                    w_busy_nxt       = 1'b0;
                    w_dwell_cnt_nxt  = '0;
                    w_state_nxt      = ST_IDLE;
                end else if (r_dwell_cnt == c_dwell_last) begin
                    w_dwell_cnt_nxt = '0;
                    if (r_index == r_last) begin
                        w_return_val_nxt = '0;
                        w_index_nxt      = '0;
                        w_busy_nxt       = 1'b0;
                        w_done_nxt       = 1'b1;
                        w_state_nxt      = ST_IDLE;
                    end else begin
                        w_index_nxt      = r_index + 1'b1;
                        w_return_val_nxt = r_return_val << 1;
                    end
                end else begin
                    w_dwell_cnt_nxt = r_dwell_cnt + 8'd1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign returnVal = r_return_val;
    assign index     = r_index;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_decoder_scan_unit                                                       |
// | Directed, table-driven bench for decoder_scan_unit in three configs.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_decoder_scan_unit;

    typedef struct {
        logic        en;
        logic        mode;
        logic        start;
        logic [4:0]  sel;
        logic [4:0]  last;
        logic [31:0] exp_rv;
        logic [4:0]  exp_idx;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        en, mode, start;
    logic [4:0]  sel, last;
    logic [31:0] a_rv, b_rv;
    logic [4:0]  a_idx, b_idx;
    logic        a_busy, a_done, b_busy, b_done;

    logic        c_en, c_mode, c_start;
    logic [0:0]  c_sel, c_last;
    logic [1:0]  c_rv;
    logic [0:0]  c_idx;
    logic        c_busy, c_done;

    int n_total = 0;
    int n_pass  = 0;

    vec_t vecs [39];

    decoder_scan_unit #(.SEL_W(5), .DWELL(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .enabled(en), .mode(mode),
        .select_bits(sel), .start(start), .scan_last(last),
        .returnVal(a_rv), .index(a_idx), .busy(a_busy), .done(a_done)
    );

    decoder_scan_unit #(.SEL_W(5), .DWELL(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .enabled(en), .mode(mode),
        .select_bits(sel), .start(start), .scan_last(last),
        .returnVal(b_rv), .index(b_idx), .busy(b_busy), .done(b_done)
    );

    decoder_scan_unit #(.SEL_W(1), .DWELL(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .enabled(c_en), .mode(c_mode),
        .select_bits(c_sel), .start(c_start), .scan_last(c_last),
        .returnVal(c_rv), .index(c_idx), .busy(c_busy), .done(c_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] c_exp_rv [7];
        logic       c_exp_dn [7];
        logic       c_exp_bz [7];

        // Direct sweep, then disable, then a short scan with last=3.
        for (int i = 0; i < 32; i++)
            vecs[i] = '{en:1'b1, mode:1'b0, start:1'b0, sel:5'(i), last:5'd0,
                        exp_rv:(32'h1 << i), exp_idx:5'd0, exp_busy:1'b0, exp_done:1'b0};
        vecs[32] = '{1'b0, 1'b0, 1'b0, 5'd9, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0};
        vecs[33] = '{1'b1, 1'b1, 1'b1, 5'd0, 5'd3, 32'h1, 5'd0, 1'b1, 1'b0};
        vecs[34] = '{1'b1, 1'b1, 1'b0, 5'd0, 5'd3, 32'h2, 5'd1, 1'b1, 1'b0};
        vecs[35] = '{1'b1, 1'b1, 1'b0, 5'd0, 5'd3, 32'h4, 5'd2, 1'b1, 1'b0};
        vecs[36] = '{1'b1, 1'b1, 1'b0, 5'd0, 5'd3, 32'h8, 5'd3, 1'b1, 1'b0};
        vecs[37] = '{1'b1, 1'b1, 1'b0, 5'd0, 5'd3, 32'h0, 5'd0, 1'b0, 1'b1};
        vecs[38] = '{1'b1, 1'b1, 1'b0, 5'd0, 5'd3, 32'h0, 5'd0, 1'b0, 1'b0};

        c_exp_rv = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
        c_exp_dn = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
        c_exp_bz = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};

        reset_n = 1'b0;
        en = 1'b0; mode = 1'b0; start = 1'b0; sel = '0; last = '0;
        c_en = 1'b0; c_mode = 1'b0; c_start = 1'b0; c_sel = '0; c_last = '0;

        #17;
        check("reset_rv",   a_rv,   32'h0);
        check("reset_idx",  a_idx,  32'h0);
        check("reset_busy", a_busy, 32'h0);
        check("reset_done", a_done, 32'h0);
        check("reset_c_rv", c_rv,   32'h0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 39; i++) begin
            en = vecs[i].en; mode = vecs[i].mode; start = vecs[i].start;
            sel = vecs[i].sel; last = vecs[i].last;
            tick();
            check($sformatf("vec%0d_rv", i),   a_rv,   vecs[i].exp_rv);
            check($sformatf("vec%0d_idx", i),  a_idx,  32'(vecs[i].exp_idx));
            check($sformatf("vec%0d_busy", i), a_busy, 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_done", i), a_done, 32'(vecs[i].exp_done));
        end
        repeat (15) tick();

        // DWELL=3 full-range scan on dut_b: index k held for 3 cycles, done at cycle 97.
        en = 1'b1; mode = 1'b1; start = 1'b1; last = 5'd31;
        for (int c = 1; c <= 97; c++) begin
            tick();
            start = 1'b0;
            if (c <= 96) begin
                check($sformatf("dwell_rv_c%0d", c),   b_rv,   32'h1 << ((c - 1) / 3));
                check($sformatf("dwell_idx_c%0d", c),  b_idx,  32'((c - 1) / 3));
                check($sformatf("dwell_busy_c%0d", c), b_busy, 32'h1);
                check($sformatf("dwell_done_c%0d", c), b_done, 32'h0);
            end else begin
                check("dwell_final_rv",   b_rv,   32'h0);
                check("dwell_final_busy", b_busy, 32'h0);
                check("dwell_final_done", b_done, 32'h1);
            end
            check($sformatf("dwell_onehot_c%0d", c), 32'($countones(b_rv) <= 1), 32'h1);
        end
        tick();
        check("dwell_done_pulse", b_done, 32'h0);

        // Inputs ignored during SCAN, then abort at index 2.
        start = 1'b1; mode = 1'b1; last = 5'd10;
        tick();
        check("abort_rv0", a_rv, 32'h1);
        mode = 1'b0; start = 1'b1; last = 5'd1; sel = 5'd3;
        tick();
        check("ignore_rv1",  a_rv,  32'h2);
        check("ignore_idx1", a_idx, 32'h1);
        tick();
        check("ignore_rv2",   a_rv,   32'h4);
        check("ignore_idx2",  a_idx,  32'h2);
        check("ignore_busy2", a_busy, 32'h1);
        en = 1'b0; mode = 1'b1; start = 1'b0;
        tick();
        check("abort_rv",   a_rv,   32'h0);
        check("abort_idx",  a_idx,  32'h0);
        check("abort_busy", a_busy, 32'h0);
        check("abort_done", a_done, 32'h0);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("abort_nodone%0d", i), a_done, 32'h0);
            check($sformatf("abort_idle_rv%0d", i), a_rv, 32'h0);
        end

        // Asynchronous reset between edges while at index 5.
        start = 1'b1; last = 5'd10;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("prereset_idx", a_idx, 32'h5);
        check("prereset_rv",  a_rv,  32'h20);
        #3 reset_n = 1'b0;
        #1;
        check("areset_rv",   a_rv,   32'h0);
        check("areset_idx",  a_idx,  32'h0);
        check("areset_busy", a_busy, 32'h0);
        #2 reset_n = 1'b1;
        mode = 1'b0; sel = 5'd7;
        tick();
        check("postreset_rv",   a_rv,   32'h80);
        check("postreset_busy", a_busy, 32'h0);

        // SEL_W=1 corner with start held: two scans separated by one zero cycle.
        c_en = 1'b1; c_mode = 1'b1; c_start = 1'b1; c_last = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 3) c_start = 1'b0;
            check($sformatf("c_rv%0d", i),   c_rv,   32'(c_exp_rv[i]));
            check($sformatf("c_done%0d", i), c_done, 32'(c_exp_dn[i]));
            check($sformatf("c_busy%0d", i), c_busy, 32'(c_exp_bz[i]));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decoder_scan_unit.md
# decoder_scan_unit

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with two modes. In direct mode it decodes `select_bits` into a registered one-hot word. In scan mode it walks an internal index from 0 to a captured upper bound, holding each one-hot output for DWELL cycles, then reports completion. It serves as the sequenced write-select and strobe generator for register-bank and peripheral-select logic, replacing fixed-width combinational decoders.

## Interface
- SEL_W, default 5: select width; output width OUT_W = 2^SEL_W (derived localparam, not overridable); legal range 1..8.
- DWELL, default 1: cycles each index is held in scan mode; legal range 1..255.

- clk  input  1  rising-edge clock; single clock domain.
- reset_n  input  1  asynchronous, active-low reset.
- enabled  input  1  global enable; low forces output to zero and aborts any scan.
- mode  input  1  0 = direct decode, 1 = scan; sampled only in IDLE.
- select_bits  input  SEL_W  decode index in direct mode.
- start  input  1  scan start request; honoured only in IDLE with mode=1 and enabled=1.
- scan_last  input  SEL_W  final scan index; captured on accepted start.
- returnVal  output  OUT_W  registered one-hot (or all-zero) output.
- index  output  SEL_W  current scan index; 0 outside SCAN.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse on normal scan completion.

## Operation
- States: IDLE and SCAN. All outputs are registered.
- Reset (reset_n low, asynchronous): state=IDLE; returnVal=0, index=0, busy=0, done=0; dwell counter and captured bound cleared.
- IDLE, enabled=0: returnVal<=0.
- IDLE, enabled=1, mode=0: returnVal <= 1<<select_bits. Start is ignored.
- IDLE, enabled=1, mode=1, start=0: returnVal<=0.
- IDLE, enabled=1, mode=1, start=1: capture scan_last; index<=0; returnVal<=1; dwell counter<=0; busy<=1; go to SCAN.
- SCAN, enabled=1:
  - The dwell counter increments each cycle.
  - When the counter reaches DWELL-1 and index<last: index+1, returnVal shifts left one position, and the counter clears.
  - When the counter reaches DWELL-1 and index==last: returnVal<=0, index<=0, busy<=0, done<=1; go to IDLE.
- SCAN, enabled=0 (abort): next cycle returnVal=0, index=0, busy=0, done stays 0; go to IDLE.
- start, mode, scan_last and select_bits are ignored during SCAN.
- done is high for exactly one cycle and is low in every other cycle.
- Invariant: returnVal has at most one bit set at all times.
- Index arithmetic is SEL_W-bit and never wraps past the captured last. scan_last = 2^SEL_W-1 is legal: all outputs are visited and the top bit is asserted last.

## Timing
- Direct mode: latency 1. select_bits sampled at edge T appears on returnVal after edge T.
- Scan, start accepted at edge T:
  - Index k is driven on returnVal from edge T+1+k*DWELL for DWELL cycles.
  - done is high, with returnVal=0, in the cycle after edge T+1+(last+1)*DWELL-1, i.e. from edge T+(last+1)*DWELL+1.
  - busy is high from edge T+1 until the done edge.
- Back-to-back scan: a start held high re-arms on the cycle after done (IDLE lasts one cycle), giving a one-cycle all-zero gap between scans.
- Abort takes effect on the edge where enabled=0 is sampled.
- Asynchronous reset mid-scan clears all outputs immediately, independent of clk. The FSM leaves reset on the first clk edge after reset_n rises.

## Test plan
- Reset, direct sweep: SEL_W=5, enabled=1, mode=0; sweep select_bits 0..31, one per cycle -> returnVal = 1<<select_bits one cycle later; set enabled=0 -> returnVal=0 next cycle; busy=0 and done=0 throughout.
- Basic scan: DWELL=1, scan_last=3, start pulse at T -> returnVal 0x1, 0x2, 0x4, 0x8 on T+1..T+4; done=1 and returnVal=0 at T+5; busy high T+1..T+4.
- Dwell and full range: DWELL=3, scan_last=31 -> each bit held 3 cycles, bit 31 last; done at T+97; returnVal is one-hot every SCAN cycle.
- Abort and ignored inputs: during SCAN, toggle mode, pulse start and change scan_last -> no effect; then drop enabled at index 2 -> returnVal=0, busy=0 next cycle, done never pulses.
- Async reset mid-scan: assert reset_n low between clock edges at index 5 -> all outputs 0 immediately; release reset_n, then mode=0, select_bits=7 -> returnVal=0x80 one cycle later.
- Parameter corners: SEL_W=1, DWELL=1, scan_last=1 -> returnVal 0b01, 0b10, then done; held start -> second scan begins after a one-cycle zero gap.
